// File: rtl/return_stack_pkg.sv
// Shared types and sizing constants for the call/return stack.
//   RS_ADDR_W : width of a PC / return address
//   RS_DEPTH  : number of stack entries (power of two, >= 2)
//   RS_SP_W   : stack pointer width, wraps modulo RS_DEPTH
//   RS_CNT_W  : occupancy counter width, holds 0..RS_DEPTH
package return_stack_pkg;

   localparam int RS_ADDR_W = 12;
   localparam int RS_DEPTH  = 8;
   localparam int RS_SP_W   = $clog2(RS_DEPTH);
   localparam int RS_CNT_W  = $clog2(RS_DEPTH + 1);

   typedef logic [RS_ADDR_W-1:0] rs_addr_t;

endpackage

// File: rtl/return_stack_mem.sv
// Entry storage for the return stack: DEPTH x ADDR_W register array.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears every entry)
//   we       : write enable
//   waddr    : write slot
//   wdata    : value written on the rising edge when we=1
//   raddr    : read slot
//   rdata    : asynchronous read of mem[raddr]
module return_stack_mem
   import return_stack_pkg::*;
#(
   parameter int ADDR_W = RS_ADDR_W,
   parameter int DEPTH  = RS_DEPTH,
   parameter int SP_W   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [SP_W-1:0]   waddr,
   input  logic [ADDR_W-1:0] wdata,
   input  logic [SP_W-1:0]   raddr,
   output logic [ADDR_W-1:0] rdata
);

   logic [ADDR_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// Hardware call/return stack sitting beside the PC register. Push stores a
// return PC; the current top entry is presented combinationally on top_addr
// so a return instruction can steer the PC mux in the same cycle it pops.
//
// Build option: define RETURN_STACK_CIRCULAR_EN to make a push into a full
// stack overwrite the oldest entry (count stays at DEPTH, ovf never set).
// Without it such a push is dropped and ovf is set.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset (priority over all)
//   en        : stall gate; 0 holds all state and ignores push/pop
//   push      : store push_addr this cycle
//   pop       : remove the top entry this cycle
//   push_addr : return address to store
//   top_addr  : current top entry, 0 when empty
//   count     : number of valid entries
//   empty     : count == 0
//   full      : count == DEPTH
//   ovf       : sticky, push rejected while full
//   unf       : sticky, pop requested while empty
//
// DEPTH must be a power of two so the pointer wraps naturally.
module return_stack
   import return_stack_pkg::*;
#(
   parameter int ADDR_W = RS_ADDR_W,
   parameter int DEPTH  = RS_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       push,
   input  logic                       pop,
   input  logic [ADDR_W-1:0]          push_addr,
   output logic [ADDR_W-1:0]          top_addr,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       ovf,
   output logic                       unf
);

   localparam int SP_W  = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [SP_W-1:0]  SP_ONE  = SP_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   logic [SP_W-1:0]   sp, sp_nxt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              ovf_nxt, unf_nxt;
   logic              we;
   logic [SP_W-1:0]   waddr;
   logic [SP_W-1:0]   sp_top;
   logic [ADDR_W-1:0] rdata;

   // sp points at the next free slot; the top entry lives one below it
   assign sp_top = sp - SP_ONE;
   assign empty  = (count == '0);
   assign full   = (count == CNT_MAX);

   return_stack_mem #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .SP_W   (SP_W)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .waddr (waddr),
      .wdata (push_addr),
      .raddr (sp_top),
      .rdata (rdata)
   );

   assign top_addr = empty ? '0 : rdata;

   always_comb begin
      we      = 1'b0;
      waddr   = sp;
      sp_nxt  = sp;
      cnt_nxt = count;
      ovf_nxt = ovf;
      unf_nxt = unf;
      if (en) begin
         if (push && pop) begin
            if (!empty) begin
               // call-after-return in one cycle: replace the top in place
               we    = 1'b1;
               waddr = sp_top;
            end else begin
               we      = 1'b1;
               sp_nxt  = sp + SP_ONE;
               cnt_nxt = CNT_ONE;
               unf_nxt = 1'b1;
            end
         end else if (push) begin
            if (!full) begin
               we      = 1'b1;
               sp_nxt  = sp + SP_ONE;
               cnt_nxt = count + CNT_ONE;
            end else begin
`ifdef RETURN_STACK_CIRCULAR_EN
               // when full, sp also addresses the oldest entry
               we     = 1'b1;
               sp_nxt = sp + SP_ONE;
`else
               ovf_nxt = 1'b1;
`endif
            end
         end else if (pop) begin
            if (!empty) begin
               sp_nxt  = sp_top;
               cnt_nxt = count - CNT_ONE;
            end else begin
               unf_nxt = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp    <= '0;
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         sp    <= sp_nxt;
         count <= cnt_nxt;
         ovf   <= ovf_nxt;
         unf   <= unf_nxt;
      end
   end

endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack: queue-based reference model, per-cycle compare on
// the falling edge, directed scenarios with literal expectations, then
// randomized push/pop/en/rst traffic.
module tb_return_stack;
   import return_stack_pkg::*;

   localparam int DEPTH = RS_DEPTH;

   logic       clk = 1'b0;
   logic       rst, en, push, pop;
   rs_addr_t   push_addr, top_addr;
   logic [3:0] count;
   logic       empty, full, ovf, unf;

   int vectors = 0;
   int fails   = 0;
   bit chk_on  = 1'b0;

   rs_addr_t mq[$];
   bit       m_ovf, m_unf;

   return_stack dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .push      (push),
      .pop       (pop),
      .push_addr (push_addr),
      .top_addr  (top_addr),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .ovf       (ovf),
      .unf       (unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model: a LIFO as a queue, back = top
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (en) begin
         if (push && pop) begin
            if (mq.size() > 0) mq[mq.size()-1] = push_addr;
            else begin
               mq.push_back(push_addr);
               m_unf = 1'b1;
            end
         end else if (push) begin
            if (mq.size() < DEPTH) mq.push_back(push_addr);
            else begin
`ifdef RETURN_STACK_CIRCULAR_EN
               void'(mq.pop_front());
               mq.push_back(push_addr);
`else
               m_ovf = 1'b1;
`endif
            end
         end else if (pop) begin
            if (mq.size() > 0) void'(mq.pop_back());
            else m_unf = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("top_addr", 32'(top_addr), (mq.size() > 0) ? 32'(mq[mq.size()-1]) : 32'd0);
         chk("count", 32'(count), 32'(mq.size()));
         chk("empty", 32'(empty), 32'(mq.size() == 0));
         chk("full", 32'(full), 32'(mq.size() == DEPTH));
         chk("ovf", 32'(ovf), 32'(m_ovf));
         chk("unf", 32'(unf), 32'(m_unf));
      end
   end

   task automatic cyc(input bit r, input bit e, input bit pu, input bit po, input rs_addr_t a);
      rst = r; en = e; push = pu; pop = po; push_addr = a;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rs_addr_t exp_top;
      rst = 1'b1; en = 1'b0; push = 1'b0; pop = 1'b0; push_addr = '0;
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 1, 1, 12'hABC);
      chk_on = 1'b1;

      // reset state
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_top", 32'(top_addr), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_unf", 32'(unf), 0);

      // basic LIFO order
      cyc(0, 1, 1, 0, 12'h010);
      cyc(0, 1, 1, 0, 12'h020);
      cyc(0, 1, 1, 0, 12'h030);
      chk("lifo_top3", 32'(top_addr), 32'h030);
      chk("lifo_cnt3", 32'(count), 3);
      for (int i = 0; i < 3; i++) begin
         exp_top = 12'h030 - 12'(i * 16);
         chk("lifo_pop_top", 32'(top_addr), 32'(exp_top));
         cyc(0, 1, 0, 1, 0);
      end
      chk("lifo_empty", 32'(empty), 1);
      chk("lifo_top0", 32'(top_addr), 0);

      // underflow, then push+pop on empty
      cyc(0, 1, 0, 1, 0);
      chk("unf_set", 32'(unf), 1);
      chk("unf_cnt", 32'(count), 0);
      cyc(0, 1, 1, 1, 12'h055);
      chk("pp_empty_cnt", 32'(count), 1);
      chk("pp_empty_top", 32'(top_addr), 32'h055);
      chk("pp_empty_unf", 32'(unf), 1);

      // fill, then push into full
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0, 12'(12'h100 + i));
      chk("fill_full", 32'(full), 1);
      cyc(0, 1, 1, 0, 12'h1FF);
      chk("ovfp_cnt", 32'(count), 8);
`ifdef RETURN_STACK_CIRCULAR_EN
      chk("ovfp_top", 32'(top_addr), 32'h1FF);
      chk("ovfp_ovf", 32'(ovf), 0);
      for (int i = 0; i < 8; i++) begin
         exp_top = (i == 0) ? 12'h1FF : 12'(12'h108 - i);
         chk("circ_pop_top", 32'(top_addr), 32'(exp_top));
         cyc(0, 1, 0, 1, 0);
      end
      chk("circ_empty", 32'(empty), 1);
`else
      chk("ovfp_top", 32'(top_addr), 32'h107);
      chk("ovfp_ovf", 32'(ovf), 1);
`endif

      // replace top in place
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 12'h0A0);
      cyc(0, 1, 1, 0, 12'h0B0);
      cyc(0, 1, 1, 1, 12'h0C0);
      chk("repl_cnt", 32'(count), 2);
      chk("repl_top", 32'(top_addr), 32'h0C0);
      cyc(0, 1, 0, 1, 0);
      chk("repl_pop_top", 32'(top_addr), 32'h0A0);

      // stall holds everything
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 12'h777);
      chk("stall_cnt", 32'(count), 1);
      chk("stall_top", 32'(top_addr), 32'h0A0);
      chk("stall_ovf", 32'(ovf), 0);
      chk("stall_unf", 32'(unf), 0);

      // reset mid-sequence
      cyc(1, 0, 0, 0, 0);
`ifdef RETURN_STACK_CIRCULAR_EN
      for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 12'(12'h200 + i));
`else
      for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 12'(12'h200 + i));
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0);
      chk("mid_ovf", 32'(ovf), 1);
`endif
      chk("mid_cnt", 32'(count), 5);
      cyc(1, 1, 1, 0, 12'h3AA);
      chk("mid_rst_cnt", 32'(count), 0);
      chk("mid_rst_empty", 32'(empty), 1);
      chk("mid_rst_ovf", 32'(ovf), 0);
      chk("mid_rst_unf", 32'(unf), 0);
      chk("mid_rst_top", 32'(top_addr), 0);

      // randomized traffic, push-biased then pop-biased
      for (int i = 0; i < 4000; i++) begin
         bit r, e, pu, po;
         r  = ($urandom_range(0, 149) == 0);
         e  = ($urandom_range(0, 7) != 0);
         if (i < 2000) begin
            pu = ($urandom_range(0, 2) != 0);
            po = ($urandom_range(0, 2) == 0);
         end else begin
            pu = ($urandom_range(0, 2) == 0);
            po = ($urandom_range(0, 2) != 0);
         end
         cyc(r, e, pu, po, rs_addr_t'($urandom_range(0, 4095)));
      end

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
- Hardware call/return stack that serves the push/pop requests the control unit issues for call and return instructions.
- On push it stores a return PC; it continuously presents the current top entry so the datapath's PC-input mux can select it on a pop.
- Sits beside the PC register in the datapath.
- Sequential LIFO with a stack pointer, full/empty status and sticky error flags.

Parameters:
- ADDR_W, 12, width of a PC / return address in bits.
- DEPTH, 8, number of stack entries; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  reset, synchronous and active-high
- en  input  1  stall gate; when 0, push/pop are ignored and all state holds
- push  input  1  push push_addr this cycle
- pop  input  1  pop the top entry this cycle
- push_addr  input  ADDR_W  return address to store
- top_addr  output  ADDR_W  current top entry; 0 when empty
- count  output  $clog2(DEPTH+1)  number of valid entries
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- ovf  output  1  sticky: push rejected because the stack was full
- unf  output  1  sticky: pop requested while the stack was empty

Behaviour:
- Reset (rst=1 at posedge): sp=0, all entries=0, count=0, empty=1, full=0, ovf=0, unf=0, top_addr=0. Reset takes priority over en/push/pop; reset mid-sequence discards all contents.
- top_addr is combinational from registered state: mem[sp-1] when count>0, else 0. Zero-latency read, so a return instruction uses top_addr in the same cycle it asserts pop.
- en=0: no state change. Flags hold.
- en=1, push only, not full: mem[sp]<=push_addr; sp<=sp+1; count+1. Visible on top_addr next cycle.
- en=1, pop only, not empty: sp<=sp-1; count-1. The entry is not cleared.
- en=1, push and pop, count>0: replace the top in place; mem[sp-1]<=push_addr, sp and count unchanged. This holds when full as well; no ovf.
- en=1, push and pop, empty: acts as a push only (count becomes 1); unf<=1.
- en=1, pop only, empty: no change; unf<=1.
- en=1, push only, full: see Optional Feature.
- sp is $clog2(DEPTH) bits and wraps modulo DEPTH; count is tracked separately so full and empty are never ambiguous.
- ovf and unf clear only on rst.

Optional Feature:
- Macro RETURN_STACK_CIRCULAR_EN.
- Defined: push when full overwrites the oldest entry. mem[sp]<=push_addr, sp wraps, count stays at DEPTH, ovf is never set. This gives deep recursion graceful degradation: the most recent DEPTH returns stay correct.
- Not defined: push when full is dropped (no state change) and ovf<=1.

Decomposition:
- Package return_stack_pkg holds: localparam RS_ADDR_W=12, RS_DEPTH=8, typedef logic [RS_ADDR_W-1:0] rs_addr_t, and the count/sp width constants derived with $clog2.
- One sub-module, return_stack_mem: DEPTH x ADDR_W register array with a synchronous write port (we, waddr, wdata), one asynchronous read port (raddr -> rdata), and synchronous reset to zero.
- Pointer, count and flag logic live in return_stack.

Test Plan:
- Reset, then push 0x010, 0x020, 0x030 -> top_addr 0x030, count 3. Three pops return 0x030, 0x020, 0x010 on top_addr before each pop edge; then empty=1, top_addr=0.
- From empty, pop alone -> unf=1, count stays 0. Then push 0x055 with pop -> count 1, top_addr 0x055, unf stays 1.
- Push 8 values 0x100..0x107 -> full=1. Push 0x1FF: without the macro -> ovf=1, top 0x107, count 8. With RETURN_STACK_CIRCULAR_EN -> top 0x1FF, count 8, ovf=0, and 8 pops yield 0x1FF, 0x107..0x101.
- Stack holds 0x0A0, 0x0B0; push 0x0C0 with pop -> count 2, top 0x0C0; pop -> top 0x0A0.
- en=0 with push and pop asserted for 3 cycles -> count, top_addr and flags unchanged.
- Assert rst mid-sequence with count=5 and ovf=1 -> next cycle count=0, empty=1, ovf=0, unf=0, top_addr=0.
